// File: rtl/double_to_long.sv
// rtl/double_to_long.sv - IEEE-754 binary64 to signed 64-bit integer converter (option: DOUBLE_TO_LONG_FLOOR_EN selects floor, else truncate)
module double_to_long (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [63:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    get_a,
    unpack,
    align,
    round,
    pack,
    put_z
  } state_t;

  state_t      state;
  logic [63:0] a_reg;
  logic [63:0] mag;
  logic [5:0]  exp_cnt;
  logic [63:0] result;
`ifdef DOUBLE_TO_LONG_FLOOR_EN
  logic        sticky;
`endif

  logic        a_sign;
  logic [10:0] a_exp;
  logic [51:0] a_frac;
  logic        a_nonzero;
  logic        too_big;
  logic        too_small;

  assign a_sign    = a_reg[63];
  assign a_exp     = a_reg[62:52];
  assign a_frac    = a_reg[51:0];
  assign a_nonzero = |a_reg[62:0];
  // Inf/NaN or unbiased exponent >= 63 (biased 1086) cannot fit a signed 64-bit result.
  assign too_big   = (a_exp == 11'h7FF) || (a_exp >= 11'd1086);
  // Unbiased exponent < 0: magnitude below 1.
  assign too_small = (a_exp < 11'd1023);

  // Conversion FSM: handshake, decode, align-by-shift, optional floor increment, sign apply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= get_a;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
    end else begin
      case (state)
        get_a: begin
          input_a_ack <= 1'b1;
          if (input_a_ack && input_a_stb) begin
            a_reg       <= input_a;
            input_a_ack <= 1'b0;
            state       <= unpack;
          end
        end

        unpack: begin
          if (too_big) begin
            result <= 64'h8000000000000000;
            state  <= put_z;
          end else if (too_small) begin
`ifdef DOUBLE_TO_LONG_FLOOR_EN
            // Any negative fraction of magnitude below 1 floors to -1.
            result <= (a_sign && a_nonzero) ? 64'hFFFFFFFFFFFFFFFF : 64'd0;
`else
            result <= 64'd0;
`endif
            state  <= put_z;
          end else begin
            mag     <= {1'b1, a_frac, 11'b0};
            // e - 1023 modulo 64 equals e[5:0] + 1; only values 0..62 reach here.
            exp_cnt <= a_exp[5:0] + 6'd1;
`ifdef DOUBLE_TO_LONG_FLOOR_EN
            sticky  <= 1'b0;
`endif
            state   <= align;
          end
        end

        align: begin
          if (exp_cnt != 6'd63) begin
            mag     <= {1'b0, mag[63:1]};
`ifdef DOUBLE_TO_LONG_FLOOR_EN
            sticky  <= sticky | mag[0];
`endif
            exp_cnt <= exp_cnt + 6'd1;
          end else begin
            state <= round;
          end
        end

        round: begin
`ifdef DOUBLE_TO_LONG_FLOOR_EN
          // Negative value with discarded fraction bits rounds away from zero.
          if (a_sign && sticky) begin
            mag <= mag + 64'd1;
          end
`endif
          state <= pack;
        end

        pack: begin
          result <= a_sign ? (64'd0 - mag) : mag;
          state  <= put_z;
        end

        put_z: begin
          output_z_stb <= 1'b1;
          output_z     <= result;
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            state        <= get_a;
          end
        end

        default: begin
          state <= get_a;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_double_to_long.sv
// tb/tb_double_to_long.sv - scoreboard testbench for double_to_long
module tb_double_to_long;

  logic        clk;
  logic        rst;
  logic [63:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [63:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  double_to_long dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

`ifdef DOUBLE_TO_LONG_FLOOR_EN
  localparam bit FLOOR = 1'b1;
`else
  localparam bit FLOOR = 1'b0;
`endif

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  logic [63:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Handshake exclusivity is watched every cycle outside reset.
  always @(negedge clk) begin
    if (!rst && input_a_ack && output_z_stb) check_val("ack_stb_excl", 64'd1, 64'd0);
  end

  // Drive one operand, push its expected result, then wait for and score the output.
  task automatic send(input logic [63:0] op, input logic [63:0] expz, input int lat, input string tag);
    int          n;
    longint      t0;
    logic [63:0] want;
    n = 0;
    @(negedge clk);
    while (!input_a_ack && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_ack"}, {63'd0, input_a_ack}, 64'd1);
    input_a     = op;
    input_a_stb = 1'b1;
    exp_q.push_back(expz);
    @(posedge clk);
    #1;
    t0          = cyc;
    input_a_stb = 1'b0;
    n = 0;
    while (!output_z_stb && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_stb"}, {63'd0, output_z_stb}, 64'd1);
    check_val({tag, "_lat"}, cyc - t0, lat);
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      check_val({tag, "_z"}, output_z, want);
    end
  endtask

  task automatic take(input string tag);
    output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    output_z_ack = 1'b0;
    check_val({tag, "_release"}, {63'd0, output_z_stb}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_stb;
    rst          = 1'b1;
    input_a      = 64'd0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_ack", {63'd0, input_a_ack}, 64'd0);
    check_val("rst_stb", {63'd0, output_z_stb}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("post_rst_ack", {63'd0, input_a_ack}, 64'd1);

    send(64'h3FF0000000000000, 64'h0000000000000001, 68, "one");      take("one");
    send(64'hBFF8000000000000, FLOOR ? 64'hFFFFFFFFFFFFFFFE : 64'hFFFFFFFFFFFFFFFF, 68, "m1p5"); take("m1p5");
    send(64'hBFD0000000000000, FLOOR ? 64'hFFFFFFFFFFFFFFFF : 64'd0, 2, "m0p25"); take("m0p25");
    send(64'h8000000000000000, 64'd0, 2, "mzero");                    take("mzero");
    send(64'h8000000000000001, FLOOR ? 64'hFFFFFFFFFFFFFFFF : 64'd0, 2, "msub"); take("msub");
    send(64'h43E0000000000000, 64'h8000000000000000, 2, "two63");     take("two63");
    send(64'h7FF8000000000000, 64'h8000000000000000, 2, "nan");       take("nan");
    send(64'hFFF0000000000000, 64'h8000000000000000, 2, "minf");      take("minf");
    send(64'h4059000000000000, 64'd100, 62, "hundred");               take("hundred");
    send(64'h43D0000000000000, 64'h4000000000000000, 6, "two62");     take("two62");
    send(64'hC3DFFFFFFFFFFFFF, 64'h8000000000000400, 6, "negmax");    take("negmax");
    send(64'hC000000000000000, 64'hFFFFFFFFFFFFFFFE, 67, "mtwo");     take("mtwo");

    // Downstream stall: result must hold and no new operand may be taken.
    send(64'h4004000000000000, 64'd2, 67, "hold");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("hold_stb", {63'd0, output_z_stb}, 64'd1);
      check_val("hold_z", output_z, 64'd2);
      check_val("hold_ack", {63'd0, input_a_ack}, 64'd0);
    end
    take("hold");

    // Reset in the middle of align discards the operand.
    @(negedge clk);
    while (!input_a_ack) @(negedge clk);
    input_a     = 64'h3FF0000000000000;
    input_a_stb = 1'b1;
    @(posedge clk);
    #1;
    input_a_stb = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen_stb = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (output_z_stb) seen_stb = 1'b1;
    end
    check_val("flush_no_stb", {63'd0, seen_stb}, 64'd0);
    check_val("flush_ack", {63'd0, input_a_ack}, 64'd1);
    send(64'h4000000000000000, 64'd2, 67, "after_rst");
    take("after_rst");
    check_val("queue_empty", exp_q.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
